// File: rtl/r4booth_pkg.sv
// r4booth_pkg: shared widths, counter width and FSM encoding for the Radix-4 Booth partial-product accumulator
package r4booth_pkg;
  localparam int PARM_MANT = 23;
  localparam int PARM_PP   = (PARM_MANT + 1) / 2 + 1;
  localparam int PARM_PPW  = 2 * PARM_MANT + 3;
  localparam int CNT_W     = $clog2(PARM_PP);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/r4booth_csa32.sv
// r4booth_csa32: PARM_PPW-bit 3:2 carry-save row
//   a_i, b_i, c_i : addends
//   sum_o         : bitwise sum
//   carry_o       : majority carries, pre-shifted left by one, carry-out of the top bit dropped
module r4booth_csa32
  import r4booth_pkg::*;
(
  input  logic [PARM_PPW-1:0] a_i,
  input  logic [PARM_PPW-1:0] b_i,
  input  logic [PARM_PPW-1:0] c_i,
  output logic [PARM_PPW-1:0] sum_o,
  output logic [PARM_PPW-1:0] carry_o
);
  logic [PARM_PPW-1:0] maj;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = {maj[PARM_PPW-2:0], 1'b0};
endmodule

// File: rtl/r4booth_pp_accumulator.sv
// r4booth_pp_accumulator: sequential carry-save fold of 13 Booth partial products plus one final carry-propagate add
//   clk_i, rst_i        : clock, async active-high reset
//   valid_i/ready_o     : input handshake for a full pp set on pp_i (ready only in IDLE)
//   pp_i                : packed partial products, pp k at [k*PARM_PPW +: PARM_PPW]
//   abort_i             : synchronous flush of the operation in flight
//   valid_o/ready_i     : output handshake for product_o
//   product_o           : low 2*PARM_MANT+2 bits of the pp sum
//   busy_o              : accumulating or doing the final add
module r4booth_pp_accumulator
  import r4booth_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [PARM_PP*PARM_PPW-1:0]   pp_i,
  input  logic                          abort_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [2*PARM_MANT+1:0]        product_o,
  output logic                          busy_o
);
  localparam int PW = 2 * PARM_MANT + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARM_PP - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PARM_PPW-1:0] sum_q, sum_d, carry_q, carry_d;
  logic [PARM_PPW-1:0] pp_cur, csa_sum, csa_carry, fin;
  logic [PARM_PP*PARM_PPW-1:0] bank_q, bank_d;
  logic [PW-1:0] prod_q, prod_d;
  // cnt stays in range while ACCUM reads the bank; later reads are unused
  assign pp_cur = bank_q[int'(cnt_q) * PARM_PPW +: PARM_PPW];
  assign fin    = sum_q + carry_q;
  r4booth_csa32 u_csa (
    .a_i     (sum_q),
    .b_i     (carry_q),
    .c_i     (pp_cur),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    bank_d  = bank_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: if (valid_i) begin
        bank_d  = pp_i;
        sum_d   = '0;
        carry_d = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        sum_d   = csa_sum;
        carry_d = csa_carry;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_LAST) ? FINAL : ACCUM;
      end
      FINAL: begin
        prod_d  = fin[PW-1:0];
        state_d = DONE;
      end
      DONE: state_d = ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // abort never touches product_o and is ignored in IDLE so a coincident accept wins
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      bank_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      bank_q  <= bank_d;
      prod_q  <= prod_d;
    end
  assign ready_o   = state_q == IDLE;
  assign valid_o   = state_q == DONE;
  assign busy_o    = state_q == ACCUM || state_q == FINAL;
  assign product_o = prod_q;
endmodule

// File: tb/tb_r4booth_pp_accumulator.sv
// tb_r4booth_pp_accumulator: random and directed checks of the Booth pp accumulator against an arithmetic model
module tb_r4booth_pp_accumulator;
  import r4booth_pkg::*;
  localparam int PW  = 2 * PARM_MANT + 2;
  localparam int PPB = PARM_PP * PARM_PPW;
  logic clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
  logic [PPB-1:0] pp_i = '0;
  logic ready_o, valid_o, busy_o;
  logic [PW-1:0] product_o;
  logic [PW-1:0] last_prod = '0;
  int checks = 0, errors = 0;
  r4booth_pp_accumulator dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .pp_i      (pp_i),
    .abort_i   (abort_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .product_o (product_o),
    .busy_o    (busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  // Booth digits of B (zero-extended) times A, each placed at weight 4^k, taken mod 2^PARM_PPW
  function automatic logic [PPB-1:0] booth_set(input logic [23:0] a, input logic [23:0] b);
    logic [PPB-1:0] r;
    logic [26:0] e;
    longint v;
    int d;
    r = '0;
    e = {2'b00, b, 1'b0};
    for (int k = 0; k < PARM_PP; k++) begin
      d = -2 * int'(e[2*k+2]) + int'(e[2*k+1]) + int'(e[2*k]);
      v = longint'(d) * longint'(a) * (longint'(1) << (2 * k));
      r[k*PARM_PPW +: PARM_PPW] = v[PARM_PPW-1:0];
    end
    return r;
  endfunction
  function automatic logic [PW-1:0] mul_ref(input logic [23:0] a, input logic [23:0] b);
    longint v;
    v = longint'(a) * longint'(b);
    return v[PW-1:0];
  endfunction
  function automatic logic [PW-1:0] pp_sum(input logic [PPB-1:0] p);
    logic [PARM_PPW-1:0] s;
    s = '0;
    for (int k = 0; k < PARM_PP; k++) s = s + p[k*PARM_PPW +: PARM_PPW];
    return s[PW-1:0];
  endfunction
  function automatic logic [PPB-1:0] rand_set();
    logic [PPB-1:0] r;
    logic [63:0] w;
    for (int k = 0; k < PARM_PP; k++) begin
      w = {$urandom, $urandom};
      r[k*PARM_PPW +: PARM_PPW] = w[PARM_PPW-1:0];
    end
    return r;
  endfunction
  // accept one set, check latency/busy/product, hold with backpressure while poking valid_i, then release
  task automatic run_op(input string tag, input logic [PPB-1:0] pp, input logic [PW-1:0] exp,
                        input int hold, input bit with_abort);
    int n, b;
    n = 0;
    while (!ready_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, ready_o, 1);
    pp_i    = pp;
    valid_i = 1'b1;
    abort_i = with_abort;
    step();
    valid_i = 1'b0;
    abort_i = 1'b0;
    pp_i    = ~pp;
    n = 0;
    b = 0;
    while (!valid_o && n < 40) begin
      if (busy_o) b++;
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 14);
    chk({tag, "_busy"}, b, 14);
    chk({tag, "_prod"}, product_o, exp);
    chk({tag, "_nrdy"}, ready_o, 0);
    valid_i = hold > 0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hv"}, valid_o, 1);
      chk({tag, "_hp"}, product_o, exp);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk({tag, "_vlo"}, valid_o, 0);
    chk({tag, "_idle"}, ready_o, 1);
    step();
    chk({tag, "_noacc"}, busy_o, 0);
    last_prod = exp;
  endtask
  initial begin
    logic [PPB-1:0] ones, p;
    logic [23:0] a, b;
    int n;
    step(2);
    chk("rst_prod", product_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    step();
    chk("rel_ready", ready_o, 1);
    chk("rel_valid", valid_o, 0);
    chk("rel_busy", busy_o, 0);
    chk("rel_prod", product_o, 0);
    ready_i = 1'b1;
    step(2);
    ready_i = 1'b0;
    chk("rdy_ignored", valid_o, 0);
    ones = '0;
    for (int k = 0; k < PARM_PP; k++) ones[k*PARM_PPW] = 1'b1;
    run_op("ones", ones, 48'd13, 0, 1'b0);
    run_op("sq80", booth_set(24'h800000, 24'h800000), 48'h400000000000, 0, 1'b0);
    run_op("sqff", booth_set(24'hFFFFFF, 24'hFFFFFF), 48'hFFFFFE000001, 5, 1'b0);
    run_op("c0a0", booth_set(24'hC00000, 24'hA00000), 48'h780000000000, 1, 1'b0);
    pp_i    = booth_set(24'h123456, 24'h654321);
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step(6);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("ab_ready", ready_o, 1);
    chk("ab_busy", busy_o, 0);
    chk("ab_prod", product_o, last_prod);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_o) n++;
      step();
    end
    chk("ab_novalid", n, 0);
    run_op("ab_sq80", booth_set(24'h800000, 24'h800000), 48'h400000000000, 0, 1'b0);
    run_op("ab_idle", booth_set(24'hABCDEF, 24'h800001), mul_ref(24'hABCDEF, 24'h800001), 0, 1'b1);
    pp_i    = rand_set();
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step(10);
    rst_i = 1'b1;
    #1;
    chk("mr_prod", product_o, 0);
    chk("mr_valid", valid_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_ready", ready_o, 1);
    step();
    rst_i = 1'b0;
    run_op("mr_next", booth_set(24'hC00000, 24'hA00000), 48'h780000000000, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 24'($urandom) | 24'h800000;
      b = 24'($urandom) | ((i % 2 == 0) ? 24'h800000 : 24'h0);
      run_op("rnd_mul", booth_set(a, b), mul_ref(a, b), $urandom_range(0, 3), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      p = rand_set();
      run_op("rnd_pp", p, pp_sum(p), $urandom_range(0, 2), 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
